// File: rtl/ir_refresh_pkg.sv
// ir_refresh_pkg: shared types and constants for the I/R refresh controller.
package ir_refresh_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RFSH_T3 = 2'd1,
    ST_RFSH_T4 = 2'd2
  } rfsh_state_t;
  localparam logic [7:0] R_MASK_LOW7 = 8'h7F;
  localparam logic [1:0] IM_MODE0 = 2'd0;
  localparam logic [1:0] IM_MODE1 = 2'd1;
  localparam logic [1:0] IM_MODE2 = 2'd2;
  localparam logic [7:0] RST_I = 8'h00;
  localparam logic [7:0] RST_R = 8'h00;
  localparam logic [1:0] RST_IM = IM_MODE0;
  function automatic logic [1:0] im_clamp(input logic [1:0] v);
    return (v == IM_MODE0) ? IM_MODE0 : (v == IM_MODE1) ? IM_MODE1 : IM_MODE2;
  endfunction
endpackage

// File: rtl/ir_refresh_fsm.sv
// ir_refresh_fsm: IDLE -> T3 -> T4 refresh slot sequencer with increment pulse on slot exit.
module ir_refresh_fsm
  import ir_refresh_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic Refresh_Start,
  output logic RFSH_Active,
  output logic incr_pulse
);
  rfsh_state_t r_state, w_next;
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = Refresh_Start ? ST_RFSH_T3 : ST_IDLE;
      ST_RFSH_T3: w_next = ST_RFSH_T4;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    RFSH_Active = r_state != ST_IDLE;
    incr_pulse  = r_state == ST_RFSH_T4;
  end
endmodule

// File: rtl/ir_refresh_control.sv
// ir_refresh_control: Z80 I/R, IFF1/IFF2, interrupt mode and M1 refresh address generation.
module ir_refresh_control
  import ir_refresh_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Refresh_Start,
  input  logic        Write_I,
  input  logic        Write_R,
  input  logic [7:0]  Data_In,
  input  logic        PA_Select_I_low,
  input  logic        PA_Select_R_low,
  input  logic        Op_EI,
  input  logic        Op_DI,
  input  logic        Op_RETN,
  input  logic        INT_Accept,
  input  logic        NMI_Accept,
  input  logic        Write_IM,
  input  logic [1:0]  IM_In,
  output logic [7:0]  Data_Out,
  output logic        PV_Out,
  output logic        RFSH_Active,
  output logic [15:0] Refresh_Addr,
  output logic        Int_Enable,
  output logic [1:0]  IM
);
  logic [7:0] r_i, r_r, w_r_inc;
  logic [1:0] r_im;
  logic r_iff1, r_iff2, r_ei_block;
  logic w_incr, w_active, w_int_di, w_ei, w_retn;
  ir_refresh_fsm u_fsm (
    .CLK          (CLK),
    .RESET        (RESET),
    .Refresh_Start(Refresh_Start),
    .RFSH_Active  (w_active),
    .incr_pulse   (w_incr)
  );
  // Only the highest-priority instruction/acknowledge event takes effect.
  assign w_int_di = ~NMI_Accept & (INT_Accept | Op_DI);
  assign w_ei     = ~NMI_Accept & ~INT_Accept & ~Op_DI & Op_EI;
  assign w_retn   = ~NMI_Accept & ~INT_Accept & ~Op_DI & ~Op_EI & Op_RETN;
  assign w_r_inc  = (r_r & ~R_MASK_LOW7) | ((r_r + 8'd1) & R_MASK_LOW7);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_i        <= RST_I;
      r_r        <= RST_R;
      r_iff1     <= 1'b0;
      r_iff2     <= 1'b0;
      r_ei_block <= 1'b0;
      r_im       <= RST_IM;
    end else begin
      if (Write_I) r_i <= Data_In;
      r_r        <= Write_R ? Data_In : w_incr ? w_r_inc : r_r;
      r_iff1     <= (NMI_Accept | w_int_di) ? 1'b0 : w_ei ? 1'b1 : w_retn ? r_iff2 : r_iff1;
      r_iff2     <= w_int_di ? 1'b0 : w_ei ? 1'b1 : r_iff2;
      // EI on the completing edge re-arms the shadow for the following instruction.
      r_ei_block <= w_ei | (~w_int_di & ~w_incr & r_ei_block);
      if (Write_IM) r_im <= im_clamp(IM_In);
    end
  end
  assign Data_Out     = PA_Select_I_low ? r_i : PA_Select_R_low ? r_r : 8'h00;
  assign PV_Out       = r_iff2;
  assign RFSH_Active  = w_active;
  assign Refresh_Addr = w_active ? {r_i, r_r} : 16'h0000;
  assign Int_Enable   = r_iff1 & ~r_ei_block;
  assign IM           = r_im;
endmodule

// File: doc/ir_refresh_control.md
# ir_refresh_control

Owns the Z80 special registers I and R, the interrupt flip-flops IFF1/IFF2 and the interrupt mode, and sequences the M1 refresh slot that drives {I,R} onto the address bus. It serves the LD A,I/R decode path: when the decoder raises `PA_Select_I_low` or `PA_Select_R_low`, this block supplies the byte and the IFF2 parity/overflow source. It also handles LD I,A / LD R,A writes, EI/DI/IM/RETN and interrupt acceptance.

## Interface
- No parameters.
- `CLK` in 1 — single clock; all state updates on its rising edge.
- `RESET` in 1 — synchronous, active-high.
- `Refresh_Start` in 1 — single-cycle pulse at T3 of every opcode fetch, including prefix fetches.
- `Write_I` in 1 — load I from `Data_In`.
- `Write_R` in 1 — load R from `Data_In`.
- `Data_In` in 8 — accumulator value for LD I,A / LD R,A.
- `PA_Select_I_low` in 1 — read I onto `Data_Out`.
- `PA_Select_R_low` in 1 — read R onto `Data_Out`.
- `Op_EI`, `Op_DI`, `Op_RETN` in 1 each — instruction strobes.
- `INT_Accept`, `NMI_Accept` in 1 each — acknowledge strobes from the interrupt logic.
- `Write_IM` in 1 — load the interrupt mode.
- `IM_In` in 2 — new mode: 0, 1 or 2.
- `Data_Out` out 8 — selected I or R value.
- `PV_Out` out 1 — current IFF2.
- `RFSH_Active` out 1 — high while the refresh slot is in progress.
- `Refresh_Addr` out 16 — {I,R} while `RFSH_Active` is high, else 0.
- `Int_Enable` out 1 — maskable interrupts may be accepted.
- `IM` out 2 — current interrupt mode.

## Operation
- **Refresh FSM states:** IDLE, RFSH_T3, RFSH_T4.
  - IDLE → RFSH_T3 on `Refresh_Start`.
  - RFSH_T3 → RFSH_T4 unconditionally.
  - RFSH_T4 → IDLE unconditionally.
  - `Refresh_Start` is ignored outside IDLE.
- **R increment:** on the RFSH_T4 → IDLE edge. R[6:0] ← R[6:0]+1 mod 128, wrapping 7F→00; R[7] is preserved.
- **R write:** if `Write_R` coincides with the increment edge, the write wins and R takes `Data_In` verbatim with no increment.
- **I write:** `Write_I` loads I; it has no interaction with the FSM.
- **Read path:** `Data_Out` is combinational from registers.
  - `PA_Select_I_low` has priority over `PA_Select_R_low`.
  - With neither select high, `Data_Out` = 0.
  - A same-cycle write is not forwarded; the read returns the old value.
- **Event priority** (one event takes effect per cycle): `NMI_Accept` > `INT_Accept` > `Op_DI` > `Op_EI` > `Op_RETN`.
  - NMI_Accept: IFF1←0, IFF2 unchanged.
  - INT_Accept or DI: IFF1←0, IFF2←0, ei_block←0.
  - EI: IFF1←1, IFF2←1, ei_block←1.
  - RETN: IFF1←IFF2.
- **EI shadow:** ei_block clears on the first refresh completion (T4 → IDLE edge) that occurs strictly after the EI cycle.
- **Outputs:** `Int_Enable` = IFF1 & ~ei_block. `PV_Out` = IFF2.
- **IM:** `Write_IM` loads `IM_In`. The value 3 is stored as 2.

## Timing
- **Reset values:** I=00, R=00, IFF1=IFF2=0, ei_block=0, IM=0, FSM=IDLE.
  - `Data_Out`=0, `PV_Out`=0, `RFSH_Active`=0, `Refresh_Addr`=0000, `Int_Enable`=0, `IM`=0.
- **`RESET` mid-refresh:** the FSM returns to IDLE, no R increment occurs, and `RFSH_Active` is low in the following cycle.
- **Refresh slot:**
  - `Refresh_Start` sampled at edge n makes `RFSH_Active` high in cycles n+1 and n+2.
  - `Refresh_Addr` shows the pre-increment R during both cycles.
  - The incremented R is visible from cycle n+3.
- **Register updates:** all register writes are visible one cycle after the strobe.
- **EI shadow timing:** EI at cycle n gives `Int_Enable`=0 until the cycle after the next refresh completion.
- **Simultaneous events:**
  - `Write_I` during the refresh slot updates `Refresh_Addr[15:8]` from the next cycle.
  - `Op_EI` on the same edge as a refresh completion keeps ei_block set.

## Structure
- **Shared package** `ir_refresh_pkg` holds:
  - the FSM state enum;
  - the R_MASK_LOW7 constant;
  - the IM encoding constants;
  - the reset constants.
- **Sub-module** `ir_refresh_fsm` holds the three-state sequencer. Its outputs are `RFSH_Active` and an `incr_pulse` asserted on the T4 → IDLE edge.
- **Parent module** holds the I/R/IFF/IM registers and the read mux.

## Test plan
- **Reset and read:** after reset, assert `PA_Select_R_low` → `Data_Out`=00, `PV_Out`=0, `Refresh_Addr`=0000.
- **Write then refresh:** `Write_I` with 3F, `Write_R` with 7F, then `Refresh_Start` → `Refresh_Addr`=3F7F for 2 cycles, after which R=00. Repeat with R=FF → R becomes 80.
- **Write vs. increment:** `Write_R` with 55 on the T4 → IDLE edge → R=55, not 56.
- **EI shadow:** EI → `Int_Enable`=0 through the next refresh slot, then 1. `NMI_Accept` → `Int_Enable`=0 and `PV_Out`=1. RETN → `Int_Enable`=1.
- **Reset mid-slot:** `RESET` in RFSH_T3 with R=10 → R=00, `RFSH_Active`=0 the next cycle. A back-to-back `Refresh_Start` during the slot is ignored, giving exactly one increment.
- **IM write:** `Write_IM` with 3 → `IM`=2.
